// File: rtl/nfc_cmd_axil_master.sv
// nfc_cmd_axil_master: AXI4-Lite master that turns one NFC command into status polls and register writes
module nfc_cmd_axil_master #(
    parameter int AXI_ADDR_WIDTH = 5,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int POLL_LIMIT     = 255
) (
    input  logic                      S_AXI_ACLK,
    input  logic                      S_AXI_ARESETN,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [47:0]               cmd_lba,
    input  logic [23:0]               cmd_len,
    input  logic [15:0]               cmd_opcode,
    output logic                      cmd_done,
    output logic [1:0]                cmd_err,
    output logic [10:0]               last_status,
    output logic [AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]                M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    if (AXI_DATA_WIDTH != 32) begin : g_bad_width
        $error("nfc_cmd_axil_master supports only a 32-bit data bus");
    end

    typedef enum logic [2:0] {IDLE, POLL_AR, POLL_R, WR, WR_B, FINISH} state_t;

    state_t      state, state_n;
    logic [47:0] lba;
    logic [23:0] len;
    logic [15:0] opcode;
    logic [15:0] poll_cnt;
    logic [15:0] poll_inc;
    logic [2:0]  idx;
    logic        aw_done, w_done, aw_ok, w_ok;
    logic [1:0]  err, err_n;
    logic        ready_en;
    logic [31:0] wdata_sel;
    logic        unused_bits;

    assign unused_bits = ^{M_AXI_RDATA[AXI_DATA_WIDTH-1:11], M_AXI_RRESP[0], M_AXI_BRESP[0]};
    assign poll_inc    = poll_cnt + 16'd1;
    assign aw_ok       = aw_done | (M_AXI_AWVALID & M_AXI_AWREADY);
    assign w_ok        = w_done | (M_AXI_WVALID & M_AXI_WREADY);

    // ready_en keeps cmd_ready low until the first clock after reset release
    assign cmd_ready     = ready_en && state == IDLE;
    assign cmd_done      = state == FINISH;
    assign cmd_err       = state == FINISH ? err : 2'b00;
    assign M_AXI_ARVALID = state == POLL_AR;
    assign M_AXI_ARADDR  = state == POLL_AR ? AXI_ADDR_WIDTH'(5'h14) : '0;
    assign M_AXI_RREADY  = state == POLL_R;
    assign M_AXI_AWVALID = state == WR && !aw_done;
    assign M_AXI_WVALID  = state == WR && !w_done;
    assign M_AXI_AWADDR  = state == WR ? AXI_ADDR_WIDTH'({idx, 2'b00}) : '0;
    assign M_AXI_WSTRB   = state == WR ? 4'hF : 4'h0;
    assign M_AXI_WDATA   = state == WR ? wdata_sel : '0;
    assign M_AXI_BREADY  = state == WR_B;

    // register image for the write currently being issued
    always_comb begin
        wdata_sel = idx == 3'd0 ? {16'h0, opcode} :
                    idx == 3'd1 ? {8'h0, len} :
                    idx == 3'd2 ? lba[31:0] :
                    idx == 3'd3 ? {16'h0, lba[47:32]} : 32'h1;
    end

    // next state and completion code
    always_comb begin
        state_n = state;
        err_n   = err;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_n = POLL_AR;
                    err_n   = 2'b00;
                end
            end
            POLL_AR: state_n = M_AXI_ARREADY ? POLL_R : POLL_AR;
            POLL_R: begin
                if (M_AXI_RVALID) begin
                    if (M_AXI_RRESP[1]) begin
                        state_n = FINISH;
                        err_n   = 2'b10;
                    end else if (!M_AXI_RDATA[0]) begin
                        state_n = WR;
                    end else if (poll_inc == 16'(POLL_LIMIT)) begin
                        state_n = FINISH;
                        err_n   = 2'b01;
                    end else begin
                        state_n = POLL_AR;
                    end
                end
            end
            WR: state_n = (aw_ok && w_ok) ? WR_B : WR;
            WR_B: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP[1]) begin
                        state_n = FINISH;
                        err_n   = 2'b11;
                    end else begin
                        state_n = idx == 3'd4 ? FINISH : WR;
                    end
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state, captured command, poll counter, write index and per-channel accept flags
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state       <= IDLE;
            err         <= 2'b00;
            ready_en    <= 1'b0;
            lba         <= '0;
            len         <= '0;
            opcode      <= '0;
            poll_cnt    <= '0;
            idx         <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            last_status <= '0;
        end else begin
            state    <= state_n;
            err      <= err_n;
            ready_en <= 1'b1;
            aw_done  <= state == WR && state_n == WR && aw_ok;
            w_done   <= state == WR && state_n == WR && w_ok;
            if (state == IDLE && cmd_valid && cmd_ready) begin
                lba      <= cmd_lba;
                len      <= cmd_len;
                opcode   <= cmd_opcode;
                poll_cnt <= '0;
                idx      <= '0;
            end
            if (state == POLL_R && M_AXI_RVALID) begin
                last_status <= M_AXI_RDATA[10:0];
                poll_cnt    <= poll_inc;
            end
            if (state == WR_B && M_AXI_BVALID && !M_AXI_BRESP[1]) idx <= idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_nfc_cmd_axil_master.sv
// tb_nfc_cmd_axil_master: directed tests of the NFC command AXI4-Lite master against a configurable slave
module tb_nfc_cmd_axil_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [47:0] cmd_lba = '0;
    logic [23:0] cmd_len = '0;
    logic [15:0] cmd_opcode = '0;
    logic        cmd_done;
    logic [1:0]  cmd_err;
    logic [10:0] last_status;
    logic [4:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int checks = 0, errors = 0;

    int aw_delay, w_delay, b_delay, ar_delay, busy_reads, rerr_at, berr_addr;
    logic [31:0] free_data;
    int aw_log [16];
    logic [31:0] w_log [16];
    int n_aw, n_w, n_aw_acc, n_w_acc, n_b, n_ar, n_ar_acc, n_r;
    int aw_wait, w_wait, b_wait, ar_wait, drops, overlap;
    bit bready_seen, rready_seen;

    always #5 clk = ~clk;

    nfc_cmd_axil_master #(.AXI_ADDR_WIDTH(5), .AXI_DATA_WIDTH(32), .POLL_LIMIT(4)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_lba(cmd_lba), .cmd_len(cmd_len),
        .cmd_opcode(cmd_opcode), .cmd_done(cmd_done), .cmd_err(cmd_err), .last_status(last_status),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // slave model: acts on falling edges, logs addresses/data and counts protocol violations
    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(negedge clk);
            if (arvalid && (awvalid || wvalid)) overlap++;
            if (awready) begin awready = 0; n_aw_acc++; aw_wait = 0; end
            else if (awvalid) begin
                if (aw_wait >= aw_delay) begin
                    awready = 1;
                    if (n_aw < 16) aw_log[n_aw] = int'(awaddr);
                    n_aw++;
                end else aw_wait++;
            end else begin
                if (aw_wait > 0 && rst_n) drops++;
                aw_wait = 0;
            end
            if (wready) begin wready = 0; n_w_acc++; w_wait = 0; end
            else if (wvalid) begin
                if (w_wait >= w_delay) begin
                    wready = 1;
                    if (n_w < 16) w_log[n_w] = (wstrb == 4'hF) ? wdata : 32'hDEAD_BEEF;
                    n_w++;
                end else w_wait++;
            end else begin
                if (w_wait > 0 && rst_n) drops++;
                w_wait = 0;
            end
            if (bvalid && bready_seen) begin bvalid = 0; n_b++; b_wait = 0; end
            else if (!bvalid && n_aw_acc > n_b && n_w_acc > n_b) begin
                if (b_wait >= b_delay) begin
                    bvalid = 1;
                    bresp = (n_b < 16 && aw_log[n_b] == berr_addr) ? 2'b10 : 2'b00;
                end else b_wait++;
            end
            bready_seen = bready;
            if (arready) begin arready = 0; n_ar_acc++; ar_wait = 0; end
            else if (arvalid) begin
                if (ar_wait >= ar_delay) begin
                    arready = 1;
                    n_ar++;
                    if (araddr != 5'h14) drops++;
                end else ar_wait++;
            end else ar_wait = 0;
            if (rvalid && rready_seen) begin rvalid = 0; n_r++; end
            else if (!rvalid && n_ar_acc > n_r) begin
                rvalid = 1;
                rdata = (n_r < busy_reads) ? 32'h0000_0405 : free_data;
                rresp = (n_r == rerr_at) ? 2'b11 : 2'b00;
            end
            rready_seen = rready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_slave(input int awd, input int wd, input int bd, input int busy,
                               input int rerr, input int berr);
        @(posedge clk);
        aw_delay = awd; w_delay = wd; b_delay = bd; ar_delay = 1;
        busy_reads = busy; rerr_at = rerr; berr_addr = berr; free_data = 32'h0;
        n_aw = 0; n_w = 0; n_aw_acc = 0; n_w_acc = 0; n_b = 0; n_ar = 0; n_ar_acc = 0; n_r = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; drops = 0; overlap = 0;
        bready_seen = 0; rready_seen = 0;
    endtask

    task automatic send_cmd(input logic [47:0] lba, input logic [23:0] len, input logic [15:0] op,
                            output logic [1:0] err, output bit got, output logic after);
        int t;
        @(negedge clk);
        cmd_valid = 1; cmd_lba = lba; cmd_len = len; cmd_opcode = op;
        t = 0;
        while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        cmd_valid = 0; cmd_lba = '1; cmd_len = '1; cmd_opcode = '1;
        t = 0;
        while (!cmd_done && t < 400) begin @(negedge clk); t++; end
        got = cmd_done;
        err = cmd_err;
        @(negedge clk);
        after = cmd_done;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({cmd_ready, arvalid, awvalid, wvalid, bready, rready, cmd_done} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {cmd_ready, arvalid, awvalid, wvalid, bready, rready, cmd_done});
        end
        checks++;
        if ({cmd_err, last_status, awaddr, araddr, wdata} !== 55'b0) begin
            errors++;
            $display("FAIL reset_data: err=%b status=%h awaddr=%h araddr=%h wdata=%h want all 0",
                     cmd_err, last_status, awaddr, araddr, wdata);
        end
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_nominal;
        logic [31:0] exp_w [5];
        logic [1:0] err;
        bit got;
        logic after;
        exp_w = '{32'h0000_00A5, 32'h0000_0200, 32'h89AB_CDEF, 32'h0000_1234, 32'h0000_0001};
        clear_slave(0, 0, 0, 0, -1, 99);
        send_cmd(48'h1234_89AB_CDEF, 24'h000200, 16'h00A5, err, got, after);
        checks++;
        if (!got || err !== 2'b00) begin errors++; $display("FAIL nom_done: done=%0d err=%b want 1/00", got, err); end
        checks++;
        if (after !== 1'b0) begin errors++; $display("FAIL nom_pulse: cmd_done next cycle %b want 0", after); end
        checks++;
        if (n_ar != 1 || n_aw != 5 || n_w != 5) begin
            errors++; $display("FAIL nom_counts: ar=%0d aw=%0d w=%0d want 1/5/5", n_ar, n_aw, n_w);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (aw_log[i] != 4 * i || w_log[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL nom_write%0d: addr=%0h data=%h want addr=%0h data=%h", i, aw_log[i], w_log[i], 4 * i, exp_w[i]);
            end
        end
        checks++;
        if (last_status !== 11'h000 || overlap != 0 || drops != 0) begin
            errors++; $display("FAIL nom_misc: status=%h overlap=%0d drops=%0d want 0/0/0", last_status, overlap, drops);
        end
    endtask

    task automatic test_backpressure;
        logic [1:0] err;
        bit got;
        logic after;
        clear_slave(0, 0, 0, 3, -1, 99);
        send_cmd(48'h0000_0000_0042, 24'h000008, 16'h0011, err, got, after);
        checks++;
        if (!got || err !== 2'b00) begin errors++; $display("FAIL bp_done: done=%0d err=%b want 1/00", got, err); end
        checks++;
        if (n_ar != 4 || n_aw != 5 || n_w != 5) begin
            errors++; $display("FAIL bp_counts: ar=%0d aw=%0d w=%0d want 4/5/5", n_ar, n_aw, n_w);
        end
        checks++;
        if (last_status[0] !== 1'b0 || w_log[2] !== 32'h0000_0042 || w_log[0] !== 32'h0000_0011) begin
            errors++; $display("FAIL bp_data: status=%h w2=%h w0=%h want 000/00000042/00000011", last_status, w_log[2], w_log[0]);
        end
    endtask

    task automatic test_timeout;
        logic [1:0] err;
        bit got;
        logic after;
        clear_slave(0, 0, 0, 100, -1, 99);
        send_cmd(48'h1, 24'h1, 16'h1, err, got, after);
        checks++;
        if (!got || err !== 2'b01) begin errors++; $display("FAIL to_done: done=%0d err=%b want 1/01", got, err); end
        checks++;
        if (n_ar != 4 || n_aw != 0 || n_w != 0) begin
            errors++; $display("FAIL to_counts: ar=%0d aw=%0d w=%0d want 4/0/0", n_ar, n_aw, n_w);
        end
        checks++;
        if (last_status !== 11'h405) begin errors++; $display("FAIL to_status: got %h want 405", last_status); end
    endtask

    task automatic test_handshake;
        logic [31:0] exp_w [5];
        logic [1:0] err;
        bit got;
        logic after;
        exp_w = '{32'h0000_BEEF, 32'h00AB_CDEF, 32'h5566_7788, 32'h0000_1122, 32'h0000_0001};
        for (int k = 0; k < 2; k++) begin
            clear_slave(k == 0 ? 3 : 0, k == 0 ? 0 : 3, 5, 0, -1, 99);
            send_cmd(48'h1122_5566_7788, 24'hABCDEF, 16'hBEEF, err, got, after);
            checks++;
            if (!got || err !== 2'b00) begin errors++; $display("FAIL hs%0d_done: done=%0d err=%b want 1/00", k, got, err); end
            checks++;
            if (n_aw != 5 || n_w != 5 || n_b != 5 || drops != 0 || overlap != 0) begin
                errors++;
                $display("FAIL hs%0d_counts: aw=%0d w=%0d b=%0d drops=%0d overlap=%0d want 5/5/5/0/0", k, n_aw, n_w, n_b, drops, overlap);
            end
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (aw_log[i] != 4 * i || w_log[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL hs%0d_write%0d: addr=%0h data=%h want addr=%0h data=%h", k, i, aw_log[i], w_log[i], 4 * i, exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_errors;
        logic [1:0] err;
        bit got;
        logic after;
        clear_slave(0, 0, 0, 0, -1, 8);
        send_cmd(48'h0000_0000_0001, 24'h2, 16'h3, err, got, after);
        checks++;
        if (!got || err !== 2'b11) begin errors++; $display("FAIL berr_done: done=%0d err=%b want 1/11", got, err); end
        checks++;
        if (n_aw != 3 || aw_log[2] != 8) begin errors++; $display("FAIL berr_writes: aw=%0d last=%0h want 3/8", n_aw, aw_log[2]); end
        clear_slave(0, 0, 0, 0, 0, 99);
        send_cmd(48'h0000_0000_0001, 24'h2, 16'h3, err, got, after);
        checks++;
        if (!got || err !== 2'b10) begin errors++; $display("FAIL rerr_done: done=%0d err=%b want 1/10", got, err); end
        checks++;
        if (n_ar != 1 || n_aw != 0) begin errors++; $display("FAIL rerr_counts: ar=%0d aw=%0d want 1/0", n_ar, n_aw); end
    endtask

    task automatic test_reset_mid;
        logic [1:0] err;
        bit got, saw_done;
        logic after;
        int t;
        clear_slave(20, 20, 0, 0, -1, 99);
        @(negedge clk);
        cmd_valid = 1; cmd_lba = 48'h7; cmd_len = 24'h7; cmd_opcode = 16'h7;
        t = 0;
        while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        cmd_valid = 0;
        t = 0;
        while (!awvalid && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (awvalid !== 1'b1) begin errors++; $display("FAIL rm_aw: awvalid %b want 1 before reset", awvalid); end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({awvalid, wvalid, arvalid, cmd_ready, cmd_done} !== 5'b0) begin
            errors++; $display("FAIL rm_drop: aw/w/ar/ready/done=%b want 00000", {awvalid, wvalid, arvalid, cmd_ready, cmd_done});
        end
        saw_done = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); saw_done |= cmd_done; end
        rst_n = 1;
        @(negedge clk);
        saw_done |= cmd_done;
        checks++;
        if (cmd_ready !== 1'b1 || saw_done) begin
            errors++; $display("FAIL rm_ready: ready=%b done_seen=%0d want 1/0", cmd_ready, saw_done);
        end
        clear_slave(0, 0, 0, 0, -1, 99);
        send_cmd(48'h0000_0000_0009, 24'h10, 16'h20, err, got, after);
        checks++;
        if (!got || err !== 2'b00 || n_aw != 5 || w_log[4] !== 32'h1 || w_log[0] !== 32'h20) begin
            errors++; $display("FAIL rm_next: done=%0d err=%b aw=%0d w4=%h w0=%h want 1/00/5/00000001/00000020", got, err, n_aw, w_log[4], w_log[0]);
        end
    endtask

    initial begin
        clear_slave(0, 0, 0, 0, -1, 99);
        repeat (2) @(negedge clk);
        test_reset;
        test_nominal;
        test_backpressure;
        test_timeout;
        test_handshake;
        test_errors;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
